// File: rtl/pcm_acr_if.sv
// pcm_acr_if: sample/tick strobes in, ACR request and N/CTS pair out.
interface pcm_acr_if;
    logic        pcm_clken;
    logic [1:0]  rate_sel;
    logic        tmds_tick;
    logic        acr;
    logic [19:0] pcm_n;
    logic [19:0] pcm_cts;
    logic        cts_valid;
    modport master (output pcm_clken, rate_sel, tmds_tick, input acr, pcm_n, pcm_cts, cts_valid);
    modport slave  (input pcm_clken, rate_sel, tmds_tick, output acr, pcm_n, pcm_cts, cts_valid);
endinterface

// File: rtl/pcm_acr_gen.sv
// pcm_acr_gen: HDMI audio clock regeneration, one ACR request every N/128 samples.
module pcm_acr_gen #(
    parameter logic [19:0] N_32K       = 20'd4096,
    parameter logic [19:0] N_44K       = 20'd6272,
    parameter logic [19:0] N_48K       = 20'd6144,
    parameter logic [19:0] CTS_32K     = 20'd27000,
    parameter logic [19:0] CTS_44K     = 20'd30000,
    parameter logic [19:0] CTS_48K     = 20'd27000,
    parameter bit          MEASURE_CTS = 1'b0,
    parameter logic [19:0] CTS_SAT     = 20'hFFFFF
) (
    input logic        clk,
    input logic        reset,
    pcm_acr_if.slave   bus
);
    logic [1:0]  rate_q, rate_p;
    logic [5:0]  cnt, last;
    logic [19:0] tick, tick_inc, n_sel, cts_sel;
    logic        chg, bnd;
    always_comb begin
        chg      = rate_q != rate_p;
        last     = rate_q == 2'd0 ? 6'd31 : rate_q == 2'd1 ? 6'd48 : 6'd47;
        bnd      = bus.pcm_clken && !chg && cnt == last;
        tick_inc = tick == CTS_SAT ? tick : tick + {19'd0, bus.tmds_tick};
        n_sel    = rate_q == 2'd0 ? N_32K : rate_q == 2'd1 ? N_44K : N_48K;
        // in measured mode the closing cycle's own tick belongs to the period it closes
        cts_sel  = MEASURE_CTS ? tick_inc : rate_q == 2'd0 ? CTS_32K : rate_q == 2'd1 ? CTS_44K : CTS_48K;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rate_q        <= 2'd2;
            rate_p        <= 2'd2;
            cnt           <= '0;
            tick          <= '0;
            bus.acr       <= 1'b0;
            bus.cts_valid <= 1'b0;
            bus.pcm_n     <= N_48K;
            bus.pcm_cts   <= MEASURE_CTS ? 20'd0 : CTS_48K;
        end else begin
            rate_q        <= bus.rate_sel;
            rate_p        <= rate_q;
            cnt           <= chg || bnd ? 6'd0 : cnt + {5'd0, bus.pcm_clken};
            tick          <= chg || bnd ? 20'd0 : tick_inc;
            bus.acr       <= bnd;
            bus.cts_valid <= !chg && (bus.cts_valid || bnd);
            if (bnd) begin
                bus.pcm_n   <= n_sel;
                bus.pcm_cts <= cts_sel;
            end
        end
    end
endmodule

// File: doc/pcm_acr_gen.md
PCM_ACR_GEN -- requirements
Module: pcm_acr_gen

Interface
REQ-001 Parameter N_32K, default 4096, HDMI N value for 32 kHz.
REQ-002 Parameter N_44K, default 6272, HDMI N value for 44.1 kHz.
REQ-003 Parameter N_48K, default 6144, HDMI N value for 48 kHz.
REQ-004 Parameter CTS_32K / CTS_44K / CTS_48K, defaults 27000 / 30000 / 27000, fixed CTS per rate.
REQ-005 Parameter MEASURE_CTS, default 0; 1 selects measured CTS instead of the fixed CTS parameters.
REQ-006 clk  in  1  single clock, all logic posedge.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 pcm_clken  in  1  one-cycle strobe per audio sample.
REQ-009 rate_sel  in  2  0=32 kHz, 1=44.1 kHz, 2=48 kHz, 3 is treated as 48 kHz.
REQ-010 tmds_tick  in  1  one-cycle strobe per TMDS character; already synchronous to clk; ignored when MEASURE_CTS=0.
REQ-011 acr  out  1  one-cycle ACR packet request pulse.
REQ-012 pcm_n  out  20  N value for the current ACR period.
REQ-013 pcm_cts  out  20  CTS value for the current ACR period.
REQ-014 cts_valid  out  1  pcm_n/pcm_cts hold a valid pair.

Function
REQ-015 The block SHALL register rate_sel into rate_q every cycle; all decisions use rate_q.
REQ-016 The block SHALL set period P = N/128 samples for rate_q: 32 for 32 kHz, 49 for 44.1 kHz, 48 for 48 kHz.
REQ-017 The 6-bit sample counter SHALL increment on pcm_clken; on pcm_clken with counter == P-1 it SHALL clear to 0 and raise a boundary event.
REQ-018 On the cycle after a boundary event, acr SHALL be 1 for exactly one cycle; latency from the closing pcm_clken to acr is 1 cycle.
REQ-019 pcm_n and pcm_cts SHALL update only in the cycle acr goes high, so the pair is stable for a whole period.
REQ-020 When MEASURE_CTS=0, the latched pair SHALL be (N, CTS) for the rate_q that governed the closing period.
REQ-021 When MEASURE_CTS=1, a 20-bit tick counter SHALL count tmds_tick since the last boundary.
REQ-022 At a boundary, pcm_cts SHALL take the tick count, including a tmds_tick in the boundary cycle, and the counter SHALL restart at 0.
REQ-023 The tick counter SHALL saturate at 0xFFFFF and not wrap.
REQ-024 When rate_q changes value, the sample counter and tick counter SHALL clear to 0, no acr SHALL be issued for the aborted period, and cts_valid SHALL drop to 0.
REQ-025 A pcm_clken in the same cycle as a rate_q change SHALL be discarded.
REQ-026 cts_valid SHALL rise together with the first acr after reset or after a rate change, and stay 1 until the next reset or rate change.
REQ-027 pcm_clken held high continuously SHALL count one sample per cycle, with no skipped or merged boundaries.

Reset
REQ-028 While reset is high, outputs SHALL be: acr=0, cts_valid=0, pcm_n=N_48K, pcm_cts=CTS_48K (MEASURE_CTS=0) or 0 (MEASURE_CTS=1).
REQ-029 While reset is high, both counters SHALL be 0 and rate_q SHALL be 2.
REQ-030 Reset asserted mid-period SHALL abandon that period; counting SHALL restart from 0 on the first clk edge after deassertion.

Verification
REQ-031 Fixed mode: rate_sel=2, 96 pcm_clken pulses -> acr one cycle after the 48th and the 96th pulse, pcm_n=6144, pcm_cts=27000, cts_valid=1 from the first acr.
REQ-032 Fixed mode: rate_sel=1, 98 pulses -> acr after pulses 49 and 98, pair (6272, 30000).
REQ-033 Rate change: rate_sel=2, 20 pulses, then rate_sel=0 -> cts_valid=0, no acr at pulse 48, next acr after 32 further pulses with pair (4096, 27000).
REQ-034 Measured mode: tmds_tick every cycle, pcm_clken every 10 cycles, rate_sel=2 -> pcm_cts=480 on each acr, pcm_n=6144.
REQ-035 Measured saturation: tmds_tick every cycle, pcm_clken stopped for more than 2^20 cycles, then completion of the period -> pcm_cts=0xFFFFF.
REQ-036 Reset pulse after 30 of 48 samples -> acr=0 and cts_valid=0 during reset; the first acr comes 48 pulses after deassertion.
